// File: rtl/lcd_char_arbiter.sv
// Round-robin arbiter sharing one ST7735 character-draw engine between three glyph requesters.
// Optional engine watchdog: define CHAR_ARB_TIMEOUT_EN to enable the WAIT-state timeout.
module lcd_char_arbiter #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd200000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic [2:0]  req,
    input  logic [20:0] req_ascii,
    input  logic [26:0] req_x,
    input  logic [26:0] req_y,
    input  logic [47:0] req_fg,
    input  logic [47:0] req_bg,
    input  logic [2:0]  req_size,
    input  logic        show_char_done,
    output logic        show_char_flag,
    output logic [6:0]  ascii_num,
    output logic [8:0]  start_x,
    output logic [8:0]  start_y,
    output logic [15:0] front_color,
    output logic [15:0] background_color,
    output logic        en_size,
    output logic [2:0]  ack,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [15:0] BG_RESET = 16'hAF7D;

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [2:0]  ack_q, ack_d;
    logic        flag_q, flag_d;
    logic [6:0]  ascii_q, ascii_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] fg_q, fg_d;
    logic [15:0] bg_q, bg_d;
    logic        size_q, size_d;
    logic        timeout_err_q, timeout_err_d;
    logic        timeout_hit;

    // Per-requester views of the packed field buses.
    logic [6:0]  fld_ascii [3];
    logic [8:0]  fld_x     [3];
    logic [8:0]  fld_y     [3];
    logic [15:0] fld_fg    [3];
    logic [15:0] fld_bg    [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fld_ascii[i] = req_ascii[7*i +: 7];
            fld_x[i]     = req_x[9*i +: 9];
            fld_y[i]     = req_y[9*i +: 9];
            fld_fg[i]    = req_fg[16*i +: 16];
            fld_bg[i]    = req_bg[16*i +: 16];
        end
    end

    // Round-robin scan starting just after the last winner; lowest offset wins.
    logic [1:0] scan_start;
    logic [2:0] scan_sum;
    logic [1:0] scan_idx;
    logic [1:0] winner;
    logic       win_valid;

    always_comb begin
        scan_start = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
        scan_sum   = '0;
        scan_idx   = '0;
        winner     = 2'd0;
        win_valid  = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            scan_sum = {1'b0, scan_start} + 3'(k);
            scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (req[scan_idx]) begin
                winner    = scan_idx;
                win_valid = 1'b1;
            end
        end
    end

`ifdef CHAR_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // Counter is zero on WAIT entry because it is held clear outside WAIT.
    always_comb begin
        wait_cnt_d  = (state_q == ST_WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
        timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_CYC - 32'd1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        ack_d         = 3'b000;
        flag_d        = 1'b0;
        ascii_d       = ascii_q;
        x_d           = x_q;
        y_d           = y_q;
        fg_d          = fg_q;
        bg_d          = bg_q;
        size_d        = size_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (init_done && win_valid) begin
                    state_d      = ST_WAIT;
                    grant_d      = winner;
                    last_grant_d = winner;
                    flag_d       = 1'b1;
                    ascii_d      = fld_ascii[winner];
                    x_d          = fld_x[winner];
                    y_d          = fld_y[winner];
                    fg_d         = fld_fg[winner];
                    bg_d         = fld_bg[winner];
                    size_d       = req_size[winner];
                end
            end
            ST_WAIT: begin
                if (show_char_done || timeout_hit) begin
                    state_d = ST_GAP;
                    ack_d   = 3'b001 << grant_q;
                    if (!show_char_done) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'd0;
            last_grant_q  <= 2'd2;
            ack_q         <= 3'b000;
            flag_q        <= 1'b0;
            ascii_q       <= 7'd0;
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            fg_q          <= 16'h0000;
            bg_q          <= BG_RESET;
            size_q        <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            ack_q         <= ack_d;
            flag_q        <= flag_d;
            ascii_q       <= ascii_d;
            x_q           <= x_d;
            y_q           <= y_d;
            fg_q          <= fg_d;
            bg_q          <= bg_d;
            size_q        <= size_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign show_char_flag   = flag_q;
    assign ascii_num        = ascii_q;
    assign start_x          = x_q;
    assign start_y          = y_q;
    assign front_color      = fg_q;
    assign background_color = bg_q;
    assign en_size          = size_q;
    assign ack              = ack_q;
    assign busy             = (state_q != ST_IDLE);
    assign timeout_err      = timeout_err_q;

endmodule
